uart_imem_loader: RTL and testbench
===================================

// Module: uart_imem_loader
// PURPOSE
//  Boot-time program loader placed upstream of PROCESSOR. Receives a program image over a UART RX line
//  and writes it word by word into instruction memory. Holds the core in reset (core_rst) until the whole
//  image is written. Replaces preloading imem from a file when running on an FPGA board.
// PARAMETERS
//  BAUD_DIV  868  clk cycles per UART bit (100 MHz / 115200); must be >= 16
//  ADDR_W    10   imem word-address width; capacity = 2**ADDR_W words
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  rst         in   1       asynchronous, active-high reset
//  uart_rx     in   1       asynchronous serial input, idle high, 8N1, LSB first
//  imem_we     out  1       one-cycle write strobe to instruction memory
//  imem_addr   out  ADDR_W  word address for the write
//  imem_wdata  out  32      word to write
//  core_rst    out  1       reset to PROCESSOR; high until load completes
//  done        out  1       load completed successfully (sticky until rst)
//  err         out  1       framing or length error (sticky until rst)
// BEHAVIOUR
//  Reset (async assert; deassert sampled on clk):
//   - imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, done=0, err=0, FSM in S_LEN, byte counter=0.
//  RX byte receiver:
//   - uart_rx passes through a 2-FF synchronizer, which resets to 1.
//   - A falling edge in idle starts a frame.
//   - The start bit is re-checked at BAUD_DIV/2; if it reads high, the frame is a glitch: return to idle, no error.
//   - Data bits are sampled every BAUD_DIV cycles after that, then the stop bit.
//   - Stop bit = 1: pulse byte_valid for 1 cycle with the byte. Stop bit = 0: pulse frame_err for 1 cycle.
//   - The receiver re-arms immediately after the stop-bit sample, so back-to-back frames are supported.
//  Image format (all fields little-endian):
//   - 4 bytes: word count N.
//   - Then N words, 4 bytes each, least significant byte first.
//  FSM states:
//   - S_LEN: collect 4 bytes into N.
//     - N==0: go to S_DONE.
//     - N > 2**ADDR_W: go to S_ERR.
//     - Otherwise: go to S_DATA with addr=0.
//   - S_DATA: shift bytes into a 32-bit assembly register.
//     - On the 4th byte of a word: in the NEXT cycle, imem_we=1 with imem_wdata = the assembled word and
//       imem_addr = the current index.
//     - The index increments after each strobe.
//     - After the strobe for word N-1, go to S_DONE.
//   - S_DONE: core_rst=0 and done=1 from the cycle after the last strobe. All further RX bytes are ignored.
//   - S_ERR: err=1, core_rst stays 1, imem_we never asserted. Only rst leaves this state.
//  Framing errors:
//   - A frame_err in S_LEN or S_DATA moves the FSM to S_ERR.
//   - In S_DONE, frame_err is ignored.
//  Outputs:
//   - imem_addr and imem_wdata hold their last values between strobes.
//   - The index width is ADDR_W+1, so that N == 2**ADDR_W terminates correctly: the last addr is all-ones
//     and there is no wrap to 0.
//  Simultaneous events:
//   - byte_valid and frame_err are mutually exclusive by construction.
//   - rst asserted at any point, including mid-frame or mid-word, aborts at once. The next load restarts at S_LEN.
//  Latency:
//   - Last stop-bit sample -> imem_we: 2 cycles (byte_valid, then strobe).
//   - Last strobe -> core_rst low: 1 cycle.
// STRUCTURE
//  - Shared package/header: FSM state encodings (S_LEN, S_DATA, S_DONE, S_ERR) and the UART frame
//    constants (start=0, stop=1, 8 data bits).
//  - One sub-module: uart_rx_byte (synchronizer, baud counter, bit FSM) with outputs byte_valid, byte,
//    frame_err.
//  - The loader FSM, byte counter (2 bits), assembly register and word index live in the top of this module.
// TESTING
//  - Bench drives uart_rx with a task sending 8N1 frames at BAUD_DIV=16 and ADDR_W=4.
//  - Bench models imem as an array written on imem_we.
//  1. Send N=2, then words 0x3C080001 and 0x00000000 -> mem[0]=0x3C080001, mem[1]=0, exactly 2 strobes,
//     core_rst falls 1 cycle after the 2nd strobe, done=1, err=0.
//  2. Send N=0 -> no strobes; done=1 and core_rst=0 one cycle after the 4th length byte.
//  3. Send N=16 (full capacity) with data i*0x01010101 -> strobes at addr 0..15 in order, no write at
//     addr 0 after 15, done=1.
//  4. Send N=17 -> err=1, core_rst=1, zero strobes; extra bytes sent afterwards cause no strobes.
//  5. Send N=1, then a data byte with stop bit 0 -> err=1 and no strobe; pulse rst, then send a valid
//     N=1 image of 0xDEADBEEF -> mem[0]=0xDEADBEEF, done=1, err=0.
//  6. 3-cycle low glitch on idle uart_rx, then rst asserted mid-way through the 2nd word of an N=2 load ->
//     glitch produces no byte; after rst all outputs are at reset values within 0 clk edges.
//  Done after rst: the bench reloads N=1, 0x12345678 and sees addr=0 written.

Source files
------------

// File: rtl/uart_imem_loader_pkg.sv
// Shared constants for the UART boot loader: loader FSM encodings, receiver
// bit-FSM encodings and the 8N1 frame layout.
package uart_imem_loader_pkg;

  localparam logic [1:0] S_LEN  = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;
  localparam int   UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_imem_loader_rx.sv
// 8N1 UART byte receiver: 2-FF synchronizer, mid-bit sampling baud counter,
// one-cycle byte_valid / frame_err pulses.
module uart_rx_byte
  import uart_imem_loader_pkg::*;
#(
  parameter int BAUD_DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);

  logic [1:0]       sync_q;
  logic             prev_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             rx_s;

  assign rx_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !rx_s) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        // A start bit that is high again at mid-bit was only a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = (rx_s == UART_START_BIT) ? RX_DATA : RX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'(UART_DATA_BITS - 1)) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_s == UART_STOP_BIT) valid_d = 1'b1;
          else                       ferr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], uart_rx};
      prev_q  <= rx_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign byte_valid = valid_q;
  assign rx_byte    = shift_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: receives a length-prefixed little-endian word image over UART,
// writes it into instruction memory and releases the core reset when complete.
module uart_imem_loader
  import uart_imem_loader_pkg::*;
#(
  parameter int BAUD_DIV = 868,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err
);

  localparam logic [31:0] CAPACITY = 32'(2 ** ADDR_W);

  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       frame_err;

  uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .frame_err  (frame_err)
  );

  logic [1:0]        state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       asm_q, asm_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              core_rst_q, core_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       word_next;

  assign word_next = {rx_byte, asm_q[31:8]};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    len_d      = len_q;
    idx_d      = idx_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    core_rst_d = core_rst_q;
    done_d     = done_q;
    err_d      = err_q;
    case (state_q)
      S_LEN: begin
        if (frame_err) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else if (byte_valid) begin
          asm_d      = word_next;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (word_next == 32'd0) begin
              state_d    = S_DONE;
              done_d     = 1'b1;
              core_rst_d = 1'b0;
            end else if (word_next > CAPACITY) begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end else begin
              state_d = S_DATA;
              len_d   = word_next[ADDR_W:0];
              idx_d   = '0;
            end
          end
        end
      end
      S_DATA: begin
        // idx_q was bumped with the strobe, so it equals len_q after the last word.
        if (frame_err) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else if (we_q && idx_q == len_q) begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          core_rst_d = 1'b0;
        end else if (byte_valid) begin
          asm_d      = word_next;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = word_next;
            addr_d  = idx_q[ADDR_W-1:0];
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_LEN;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rst   = core_rst_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench for uart_imem_loader: drives 8N1 frames and checks an imem write log.
module tb_uart_imem_loader;

  localparam int BAUD_DIV = 16;
  localparam int ADDR_W   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              uart_rx = 1'b1;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_imem_loader #(.BAUD_DIV(BAUD_DIV), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .err        (err)
  );

  // imem model and write log, sampled on the falling edge
  logic [31:0] mem [16];
  int          cycle = 0;
  int          wr_cnt = 0;
  int          log_addr [64];
  logic [31:0] log_data [64];
  int          log_cyc  [64];
  int          fall_cyc = -1;
  logic        core_rst_prev = 1'b1;

  always @(negedge clk) begin
    cycle = cycle + 1;
    if (core_rst_prev && !core_rst) fall_cyc = cycle;
    core_rst_prev = core_rst;
    if (imem_we) begin
      mem[imem_addr] = imem_wdata;
      if (wr_cnt < 64) begin
        log_addr[wr_cnt] = int'(imem_addr);
        log_data[wr_cnt] = imem_wdata;
        log_cyc[wr_cnt]  = cycle;
      end
      $display("imem write #%0d addr=%0d data=%08h cycle=%0d", wr_cnt, imem_addr, imem_wdata, cycle);
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    wait_cycles(1);
    uart_rx = 1'b0;
    wait_cycles(BAUD_DIV);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_cycles(BAUD_DIV);
    end
    uart_rx = stop;
    wait_cycles(BAUD_DIV);
    uart_rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0], 1'b1);
    send_byte(w[15:8], 1'b1);
    send_byte(w[23:16], 1'b1);
    send_byte(w[31:24], 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    uart_rx = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(3);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cycles(3);
    n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b want=0", imem_we); end
    n_checks++; if (imem_addr !== 4'd0) begin n_fail++; $display("FAIL reset_addr got=%0d want=0", imem_addr); end
    n_checks++; if (imem_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata got=%08h want=0", imem_wdata); end
    n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL reset_core_rst got=%b want=1", core_rst); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b want=0", err); end
  endtask

  task automatic test_basic_load();
    int base;
    do_reset();
    base = wr_cnt;
    send_word(32'd2);
    send_word(32'h3C08_0001);
    send_word(32'h0000_0000);
    wait_cycles(4);
    n_checks++; if (wr_cnt - base !== 2) begin n_fail++; $display("FAIL basic_strobes got=%0d want=2", wr_cnt - base); end
    n_checks++; if (log_addr[base] !== 0 || log_data[base] !== 32'h3C08_0001) begin n_fail++; $display("FAIL basic_w0 got=%0d/%08h want=0/3c080001", log_addr[base], log_data[base]); end
    n_checks++; if (log_addr[base+1] !== 1 || log_data[base+1] !== 32'h0) begin n_fail++; $display("FAIL basic_w1 got=%0d/%08h want=1/00000000", log_addr[base+1], log_data[base+1]); end
    n_checks++; if (mem[0] !== 32'h3C08_0001 || mem[1] !== 32'h0) begin n_fail++; $display("FAIL basic_mem got=%08h/%08h want=3c080001/00000000", mem[0], mem[1]); end
    n_checks++; if (fall_cyc - log_cyc[base+1] !== 1) begin n_fail++; $display("FAIL basic_latency got=%0d want=1", fall_cyc - log_cyc[base+1]); end
    n_checks++; if (done !== 1'b1 || err !== 1'b0 || core_rst !== 1'b0) begin n_fail++; $display("FAIL basic_status got=done%b err%b crst%b want=done1 err0 crst0", done, err, core_rst); end
  endtask

  task automatic test_zero_len();
    int base;
    do_reset();
    base = wr_cnt;
    send_word(32'd0);
    wait_cycles(2);
    n_checks++; if (wr_cnt - base !== 0) begin n_fail++; $display("FAIL zero_strobes got=%0d want=0", wr_cnt - base); end
    n_checks++; if (done !== 1'b1 || core_rst !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL zero_status got=done%b crst%b err%b want=done1 crst0 err0", done, core_rst, err); end
  endtask

  task automatic test_full_capacity();
    int base;
    do_reset();
    base = wr_cnt;
    send_word(32'd16);
    for (int i = 0; i < 16; i++) send_word(32'(i) * 32'h0101_0101);
    wait_cycles(4);
    n_checks++; if (wr_cnt - base !== 16) begin n_fail++; $display("FAIL full_strobes got=%0d want=16", wr_cnt - base); end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (log_addr[base+i] !== i || log_data[base+i] !== 32'(i) * 32'h0101_0101) begin
        n_fail++;
        $display("FAIL full_word%0d got=%0d/%08h want=%0d/%08h", i, log_addr[base+i], log_data[base+i], i, 32'(i) * 32'h0101_0101);
      end
    end
    n_checks++; if (done !== 1'b1 || err !== 1'b0 || core_rst !== 1'b0) begin n_fail++; $display("FAIL full_status got=done%b err%b crst%b want=done1 err0 crst0", done, err, core_rst); end
  endtask

  task automatic test_over_len();
    int base;
    do_reset();
    base = wr_cnt;
    send_word(32'd17);
    wait_cycles(2);
    n_checks++; if (err !== 1'b1 || core_rst !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL over_status got=err%b crst%b done%b want=err1 crst1 done0", err, core_rst, done); end
    send_word(32'h1122_3344);
    send_word(32'h0000_0001);
    wait_cycles(4);
    n_checks++; if (wr_cnt - base !== 0) begin n_fail++; $display("FAIL over_strobes got=%0d want=0", wr_cnt - base); end
    n_checks++; if (err !== 1'b1 || core_rst !== 1'b1) begin n_fail++; $display("FAIL over_sticky got=err%b crst%b want=err1 crst1", err, core_rst); end
  endtask

  task automatic test_frame_err();
    int base;
    do_reset();
    base = wr_cnt;
    send_word(32'd1);
    send_byte(8'hAA, 1'b0);
    wait_cycles(4);
    n_checks++; if (err !== 1'b1 || core_rst !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL ferr_status got=err%b crst%b done%b want=err1 crst1 done0", err, core_rst, done); end
    n_checks++; if (wr_cnt - base !== 0) begin n_fail++; $display("FAIL ferr_strobes got=%0d want=0", wr_cnt - base); end
    do_reset();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ferr_cleared got=%b want=0", err); end
    base = wr_cnt;
    send_word(32'd1);
    send_word(32'hDEAD_BEEF);
    wait_cycles(4);
    n_checks++; if (wr_cnt - base !== 1 || log_addr[base] !== 0) begin n_fail++; $display("FAIL reload_strobe got=%0d@%0d want=1@0", wr_cnt - base, log_addr[base]); end
    n_checks++; if (mem[0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL reload_mem got=%08h want=deadbeef", mem[0]); end
    n_checks++; if (done !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL reload_status got=done%b err%b want=done1 err0", done, err); end
  endtask

  task automatic test_glitch_and_abort();
    int base;
    do_reset();
    base = wr_cnt;
    uart_rx = 1'b0;
    wait_cycles(3);
    uart_rx = 1'b1;
    wait_cycles(40);
    send_word(32'd2);
    send_word(32'hA5A5_1234);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    n_checks++; if (wr_cnt - base !== 1 || log_data[base] !== 32'hA5A5_1234) begin n_fail++; $display("FAIL glitch_word0 got=%0d/%08h want=1/a5a51234", wr_cnt - base, log_data[base]); end
    n_checks++; if (err !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL glitch_status got=err%b done%b want=err0 done0", err, done); end
    // abort inside the third byte of word 1, between clock edges
    uart_rx = 1'b0;
    wait_cycles(40);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (imem_we !== 1'b0 || imem_addr !== 4'd0 || imem_wdata !== 32'd0) begin n_fail++; $display("FAIL abort_imem got=we%b addr%0d data%08h want=we0 addr0 data0", imem_we, imem_addr, imem_wdata); end
    n_checks++; if (core_rst !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL abort_status got=crst%b done%b err%b want=crst1 done0 err0", core_rst, done, err); end
    uart_rx = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(3);
    base = wr_cnt;
    send_word(32'd1);
    send_word(32'h1234_5678);
    wait_cycles(4);
    n_checks++; if (wr_cnt - base !== 1 || log_addr[base] !== 0 || log_data[base] !== 32'h1234_5678) begin n_fail++; $display("FAIL after_abort got=%0d %0d/%08h want=1 0/12345678", wr_cnt - base, log_addr[base], log_data[base]); end
    n_checks++; if (done !== 1'b1 || core_rst !== 1'b0) begin n_fail++; $display("FAIL after_abort_status got=done%b crst%b want=done1 crst0", done, core_rst); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_zero_len();
    test_full_capacity();
    test_over_len();
    test_frame_err();
    test_glitch_and_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
